sm2201_camac_cycle_sequencer: RTL
=================================

SM2201_CAMAC_CYCLE_SEQUENCER -- requirements
Module: sm2201_camac_cycle_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port isa_clk, reset port isa_reset.
REQ-002 The block SHALL have parameter T_SETUP, default 2, meaning NAF/B setup cycles before S1 (legal 1..15).
REQ-003 The block SHALL have parameter T_STROBE, default 3, meaning S1 and S2 width in cycles (legal 1..15).
REQ-004 The block SHALL have parameter T_GAP, default 2, meaning cycles between S1 fall and S2 rise (legal 1..15).
REQ-005 The block SHALL have parameter T_HOLD, default 1, meaning NAF/B hold cycles after S2 (legal 1..15).
REQ-006 Ports SHALL be, one per line:
- isa_clk  in  1  ISA bus clock
- isa_reset  in  1  synchronous reset, active high
- req  in  1  one-cycle start pulse from the ISA port decoder
- req_n / req_a / req_f  in  5/4/5  station, subaddress, function
- req_wdata  in  24  write data
- camac_r  in  24  dataway read lines
- camac_q / camac_x  in  1/1  Q and X responses
- camac_l  in  1  LAM request, asynchronous
- lam_en  in  1  LAM interrupt enable
- camac_n / camac_a / camac_f  out  5/4/5  registered NAF
- camac_w  out  24  write lines
- camac_b / camac_s1 / camac_s2  out  1 each  busy and strobes
- rdata  out  24  latched read data
- q_out / x_out  out  1/1  latched Q/X
- busy / done  out  1/1  cycle in progress / one-cycle completion pulse
- isa_chrdy  out  1  ISA channel ready; low inserts wait states
- isa_irq_lam  out  1  LAM interrupt request

Function
REQ-007 The FSM SHALL use states IDLE, SETUP, S1, GAP, S2, HOLD, DONE, driven by a 4-bit down-counter.
REQ-008 In IDLE, req=1 at edge k SHALL latch N/A/F/wdata and enter SETUP at k+1.
REQ-009 Each timed state SHALL last exactly its parameter in cycles; order SHALL be SETUP->S1->GAP->S2->HOLD->DONE->IDLE, with DONE lasting 1 cycle.
REQ-010 With defaults, done=1 SHALL occur in cycle k+12, and isa_chrdy=0 SHALL hold in cycles k+1..k+11.
REQ-011 camac_b and busy SHALL be 1 in SETUP..HOLD; camac_s1=1 only in S1; camac_s2=1 only in S2; all outputs SHALL be registered.
REQ-012 camac_n/a/f SHALL be driven from SETUP through HOLD and SHALL be 0 in IDLE/DONE.
REQ-013 Read (F=0..7): camac_r, camac_q and camac_x SHALL be latched on the last S1 cycle into rdata/q_out/x_out.
REQ-014 Write (F=16..23): camac_w SHALL equal latched wdata from SETUP through HOLD and 0 otherwise; rdata SHALL be unchanged.
REQ-015 Control (other F): no data SHALL be driven or latched, but q_out/x_out SHALL be latched as for read.
REQ-016 req while busy or in DONE SHALL be ignored with no effect on the running cycle.
REQ-017 isa_chrdy SHALL be 1 in IDLE and DONE.

Reset
REQ-018 isa_reset=1 at an edge SHALL force IDLE and all outputs to 0, except isa_chrdy=1, including mid-cycle; strobes SHALL drop on that same edge.
REQ-019 A req coincident with reset SHALL be discarded.

Configuration
REQ-020 With macro SM2201_CAMAC_LAM_IRQ_EN defined, camac_l SHALL pass a 2-flop synchronizer, and isa_irq_lam SHALL equal the synced LAM AND lam_en, 2 cycles after a camac_l rise, cleared by reset.
REQ-021 Without SM2201_CAMAC_LAM_IRQ_EN, isa_irq_lam SHALL be constant 0, lam_en and camac_l SHALL be unused, and no synchronizer flops SHALL exist.

Verification
REQ-022 Read N=5 A=2 F=0, camac_r=0xA5C3F0, q=1, x=1 -> rdata=0xA5C3F0, q_out=1, x_out=1, done at k+12, S1 high k+3..k+5, S2 high k+8..k+10.
REQ-023 Write N=1 A=0 F=16, wdata=0x123456 -> camac_w=0x123456 during k+1..k+11 then 0; rdata unchanged; isa_chrdy low k+1..k+11.
REQ-024 Second req at k+4 during a cycle -> ignored; exactly one done pulse; NAF unchanged.
REQ-025 isa_reset=1 at k+6 during S2-bound cycle -> all strobes, B and busy 0 and isa_chrdy=1 at k+6; a new req at k+8 completes normally.
REQ-026 With SM2201_CAMAC_LAM_IRQ_EN, lam_en=1, camac_l rises -> isa_irq_lam=1 two cycles later; lam_en=0 -> 0; without the macro -> always 0.

Source files
------------

// File: rtl/sm2201_camac_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// sm2201_camac_cycle_sequencer
//
// Runs a single CAMAC dataway cycle for an ISA host. The cycle sequence is
// NAF/B setup, S1 strobe, gap, S2 strobe, NAF/B hold, then a one-cycle DONE.
// Each timed phase is a parameter. The ISA channel-ready line is held low
// while the cycle runs, so the host sees wait states.
//
// Optional feature: when the macro SM2201_CAMAC_LAM_IRQ_EN is defined, the
// asynchronous LAM line passes through a 2-flop synchronizer and is gated by
// lam_en onto isa_irq_lam. When the macro is undefined, isa_irq_lam is tied
// to 0 and the build contains no synchronizer flops.
//
// Ports
//   isa_clk, isa_reset           clock, synchronous active-high reset
//   req                          one-cycle start pulse (ignored unless idle)
//   req_n/req_a/req_f/req_wdata  station, subaddress, function, write data
//   camac_r, camac_q, camac_x    dataway read lines and Q/X responses
//   camac_l, lam_en              LAM request (async) and interrupt enable
//   camac_n/a/f, camac_w         registered NAF and write lines
//   camac_b, camac_s1, camac_s2  busy and strobes
//   rdata, q_out, x_out          latched read data and Q/X
//   busy, done                   cycle in progress / completion pulse
//   isa_chrdy                    ISA channel ready (low = wait)
//   isa_irq_lam                  LAM interrupt request
// ---------------------------------------------------------------------------
module sm2201_camac_cycle_sequencer #(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 3,
    parameter int T_GAP    = 2,
    parameter int T_HOLD   = 1
) (
    input  logic        isa_clk,
    input  logic        isa_reset,
    input  logic        req,
    input  logic [4:0]  req_n,
    input  logic [3:0]  req_a,
    input  logic [4:0]  req_f,
    input  logic [23:0] req_wdata,
    input  logic [23:0] camac_r,
    input  logic        camac_q,
    input  logic        camac_x,
    input  logic        camac_l,
    input  logic        lam_en,
    output logic [4:0]  camac_n,
    output logic [3:0]  camac_a,
    output logic [4:0]  camac_f,
    output logic [23:0] camac_w,
    output logic        camac_b,
    output logic        camac_s1,
    output logic        camac_s2,
    output logic [23:0] rdata,
    output logic        q_out,
    output logic        x_out,
    output logic        busy,
    output logic        done,
    output logic        isa_chrdy,
    output logic        isa_irq_lam
);

    typedef enum logic [2:0] {IDLE, SETUP, S1, GAP, S2, HOLD, DONE} state_t;

    // The counter is loaded with (length - 1) on entry and the state advances when it reaches 0.
    localparam logic [3:0] LD_SETUP  = 4'(T_SETUP - 1);
    localparam logic [3:0] LD_STROBE = 4'(T_STROBE - 1);
    localparam logic [3:0] LD_GAP    = 4'(T_GAP - 1);
    localparam logic [3:0] LD_HOLD   = 4'(T_HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  n_q, n_d, f_q, f_d;
    logic [3:0]  a_q, a_d;
    logic [23:0] wd_q, wd_d;

    // Output registers
    logic [4:0]  camac_n_q, camac_n_d, camac_f_q, camac_f_d;
    logic [3:0]  camac_a_q, camac_a_d;
    logic [23:0] camac_w_q, camac_w_d, rdata_q, rdata_d;
    logic        busy_q, busy_d, s1_q, s1_d, s2_q, s2_d;
    logic        done_q, done_d, chrdy_q, chrdy_d;
    logic        q_out_q, q_out_d, x_out_q, x_out_d;

    logic        active_d, is_write_d, is_read_q, sample_s1;

    // Next-state logic and command latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        a_d     = a_q;
        f_d     = f_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SETUP;
                    cnt_d   = LD_SETUP;
                    n_d     = req_n;
                    a_d     = req_a;
                    f_d     = req_f;
                    wd_d    = req_wdata;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin state_d = S1; cnt_d = LD_STROBE; end
                else cnt_d = cnt_q - 4'd1;
            end
            S1: begin
                if (cnt_q == 4'd0) begin state_d = GAP; cnt_d = LD_GAP; end
                else cnt_d = cnt_q - 4'd1;
            end
            GAP: begin
                if (cnt_q == 4'd0) begin state_d = S2; cnt_d = LD_STROBE; end
                else cnt_d = cnt_q - 4'd1;
            end
            S2: begin
                if (cnt_q == 4'd0) begin state_d = HOLD; cnt_d = LD_HOLD; end
                else cnt_d = cnt_q - 4'd1;
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin state_d = DONE; cnt_d = 4'd0; end
                else cnt_d = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that each registered output
    // changes on the same edge as the state it belongs to.
    always_comb begin
        active_d   = (state_d == SETUP) || (state_d == S1) || (state_d == GAP) ||
                     (state_d == S2) || (state_d == HOLD);
        is_write_d = (f_d[4:3] == 2'b10);  // F16..F23
        is_read_q  = (f_q[4:3] == 2'b00);  // F0..F7
        // The edge that ends the last S1 cycle is the one where the read lines are valid.
        sample_s1  = (state_q == S1) && (cnt_q == 4'd0);

        camac_n_d = active_d ? n_d : 5'd0;
        camac_a_d = active_d ? a_d : 4'd0;
        camac_f_d = active_d ? f_d : 5'd0;
        camac_w_d = (active_d && is_write_d) ? wd_d : 24'd0;
        busy_d    = active_d;
        s1_d      = (state_d == S1);
        s2_d      = (state_d == S2);
        done_d    = (state_d == DONE);
        chrdy_d   = !active_d;

        rdata_d   = rdata_q;
        q_out_d   = q_out_q;
        x_out_d   = x_out_q;
        if (sample_s1) begin
            q_out_d = camac_q;
            x_out_d = camac_x;
            if (is_read_q) rdata_d = camac_r;
        end
    end

    always_ff @(posedge isa_clk) begin
        if (isa_reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            n_q       <= 5'd0;
            a_q       <= 4'd0;
            f_q       <= 5'd0;
            wd_q      <= 24'd0;
            camac_n_q <= 5'd0;
            camac_a_q <= 4'd0;
            camac_f_q <= 5'd0;
            camac_w_q <= 24'd0;
            busy_q    <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            done_q    <= 1'b0;
            chrdy_q   <= 1'b1;
            rdata_q   <= 24'd0;
            q_out_q   <= 1'b0;
            x_out_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            a_q       <= a_d;
            f_q       <= f_d;
            wd_q      <= wd_d;
            camac_n_q <= camac_n_d;
            camac_a_q <= camac_a_d;
            camac_f_q <= camac_f_d;
            camac_w_q <= camac_w_d;
            busy_q    <= busy_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            done_q    <= done_d;
            chrdy_q   <= chrdy_d;
            rdata_q   <= rdata_d;
            q_out_q   <= q_out_d;
            x_out_q   <= x_out_d;
        end
    end

    assign camac_n   = camac_n_q;
    assign camac_a   = camac_a_q;
    assign camac_f   = camac_f_q;
    assign camac_w   = camac_w_q;
    assign camac_b   = busy_q;
    assign busy      = busy_q;
    assign camac_s1  = s1_q;
    assign camac_s2  = s2_q;
    assign done      = done_q;
    assign isa_chrdy = chrdy_q;
    assign rdata     = rdata_q;
    assign q_out     = q_out_q;
    assign x_out     = x_out_q;

`ifdef SM2201_CAMAC_LAM_IRQ_EN
    logic lam_m_q, lam_s_q;

    always_ff @(posedge isa_clk) begin
        if (isa_reset) begin
            lam_m_q <= 1'b0;
            lam_s_q <= 1'b0;
        end else begin
            lam_m_q <= camac_l;
            lam_s_q <= lam_m_q;
        end
    end

    assign isa_irq_lam = lam_s_q & lam_en;
`else
    logic lam_unused;
    assign lam_unused  = camac_l ^ lam_en;
    assign isa_irq_lam = 1'b0;
`endif

endmodule
